program_selector: RTL and testbench

Front-panel program selection stage that directly feeds the 7-segment display controller's `pick`/`block` inputs. Four raw push-buttons are synchronised, debounced and edge-detected. They step a program index and a program bank, each with per-bank wrap limits. A load request is issued to the downstream program loader through a req/ack handshake.

---
 rtl/selector_pkg.sv | 77 +++++++
 rtl/program_selector_if.sv | 31 +++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/program_selector.sv | 100 ++++++++++
 tb/tb_program_selector.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/selector_pkg.sv
// -----------------------------------------------------------------------------
// selector_pkg
// Shared constants, types and helpers for the front-panel program selector.
//   NUM_BANKS   : number of program banks
//   BANK_SIZE   : programs per bank, indexed by bank number
//   PICK_W      : width of the program index
//   BLOCK_W     : width of the bank index
//   sel_state_e : load-handshake FSM states
//   BTN_*       : bit positions of the four buttons in packed button vectors
// -----------------------------------------------------------------------------
package selector_pkg;

    localparam int NUM_BANKS = 3;
    localparam int PICK_W    = 4;
    localparam int BLOCK_W   = 2;

    localparam logic [PICK_W-1:0] BANK_SIZE [NUM_BANKS] = '{4'd10, 4'd10, 4'd5};

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_BLOCK = 2;
    localparam int BTN_LOAD  = 3;
    localparam int NUM_BTNS  = 4;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_PEND = 1'b1
    } sel_state_e;

    // Highest legal program index in a bank; unreachable bank 3 maps to 0.
    function automatic logic [PICK_W-1:0] pick_last(input logic [BLOCK_W-1:0] blk);
        logic [PICK_W-1:0] last_s;
        case (blk)
            2'd0:    last_s = BANK_SIZE[0] - 4'd1;
            2'd1:    last_s = BANK_SIZE[1] - 4'd1;
            2'd2:    last_s = BANK_SIZE[2] - 4'd1;
            default: last_s = 4'd0;
        endcase
        return last_s;
    endfunction

    // Next program index, wrapping to 0 past the bank's last entry.
    function automatic logic [PICK_W-1:0] pick_inc(input logic [PICK_W-1:0] pick,
                                                  input logic [BLOCK_W-1:0] blk);
        logic [PICK_W-1:0] nxt_s;
        if (pick >= pick_last(blk)) begin
            nxt_s = 4'd0;
        end else begin
            nxt_s = pick + 4'd1;
        end
        return nxt_s;
    endfunction

    // Previous program index, wrapping from 0 to the bank's last entry.
    function automatic logic [PICK_W-1:0] pick_dec(input logic [PICK_W-1:0] pick,
                                                  input logic [BLOCK_W-1:0] blk);
        logic [PICK_W-1:0] nxt_s;
        if ((pick == 4'd0) || (pick > pick_last(blk))) begin
            nxt_s = pick_last(blk);
        end else begin
            nxt_s = pick - 4'd1;
        end
        return nxt_s;
    endfunction

    // Next bank, wrapping 2 -> 0 so value 3 never appears.
    function automatic logic [BLOCK_W-1:0] block_inc(input logic [BLOCK_W-1:0] blk);
        logic [BLOCK_W-1:0] nxt_s;
        if (blk >= 2'(NUM_BANKS - 1)) begin
            nxt_s = 2'd0;
        end else begin
            nxt_s = blk + 2'd1;
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/program_selector_if.sv
// -----------------------------------------------------------------------------
// program_selector_if
// Selection/load bus between the program selector and the loader/display.
//   pick     : program index within the bank
//   block    : bank index
//   load_req : load request, pick/block stable while high
//   load_ack : loader acknowledge
// master = selector side, slave = loader side.
// -----------------------------------------------------------------------------
interface program_selector_if;

    logic [selector_pkg::PICK_W-1:0]  pick;
    logic [selector_pkg::BLOCK_W-1:0] block;
    logic                             load_req;
    logic                             load_ack;

    modport master (
        output pick,
        output block,
        output load_req,
        input  load_ack
    );

    modport slave (
        input  pick,
        input  block,
        input  load_req,
        output load_ack
    );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// 2-flop synchroniser, consecutive-cycle debouncer and rising-edge detector
// for one raw push-button.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_raw : raw asynchronous button
//   level   : debounced level
//   press   : one-cycle pulse on a debounced rising edge
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter, level flip after a full run of differing samples, press pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                // Any sample agreeing with the current level restarts the run.
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= sync2_r;
                press_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/program_selector.sv
// -----------------------------------------------------------------------------
// program_selector
// Front-panel program selection: four debounced buttons step a program index
// and bank with per-bank wrap limits, and a load button raises a req/ack load
// request towards the program loader.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   btn_up    : raw button, next program
//   btn_down  : raw button, previous program
//   btn_block : raw button, next bank
//   btn_load  : raw button, request load
//   bus       : pick/block/load_req out, load_ack in (master side)
// -----------------------------------------------------------------------------
module program_selector
    import selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_block,
    input  logic                      btn_load,
    program_selector_if.master        bus
);

    logic [NUM_BTNS-1:0] raw_s;
    logic [NUM_BTNS-1:0] press_s;
    logic [NUM_BTNS-1:0] level_unused_s;

    sel_state_e          state_r;
    logic [PICK_W-1:0]   pick_r;
    logic [BLOCK_W-1:0]  block_r;
    logic                load_req_r;

    assign raw_s[BTN_UP]    = btn_up;
    assign raw_s[BTN_DOWN]  = btn_down;
    assign raw_s[BTN_BLOCK] = btn_block;
    assign raw_s[BTN_LOAD]  = btn_load;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(raw_s[g]),
            .level  (level_unused_s[g]),
            .press  (press_s[g])
        );
    end

    // Load-handshake FSM and pick/block registers; priority load > block > up/down
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pick_r     <= {PICK_W{1'b0}};
            block_r    <= {BLOCK_W{1'b0}};
            load_req_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (press_s[BTN_LOAD]) begin
                        state_r    <= LOAD_PEND;
                        load_req_r <= 1'b1;
                    end else if (press_s[BTN_BLOCK]) begin
                        block_r <= block_inc(block_r);
                        pick_r  <= {PICK_W{1'b0}};
                    end else if (press_s[BTN_UP] && !press_s[BTN_DOWN]) begin
                        pick_r <= pick_inc(pick_r, block_r);
                    end else if (press_s[BTN_DOWN] && !press_s[BTN_UP]) begin
                        pick_r <= pick_dec(pick_r, block_r);
                    end else begin
                        // No event, or up and down cancelling each other.
                        pick_r <= pick_r;
                    end
                end
                LOAD_PEND: begin
                    // Selection frozen and button events dropped until acknowledged.
                    if (bus.load_ack) begin
                        state_r    <= IDLE;
                        load_req_r <= 1'b0;
                    end else begin
                        load_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    load_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pick     = pick_r;
    assign bus.block    = block_r;
    assign bus.load_req = load_req_r;

endmodule

// File: tb/tb_program_selector.sv
// -----------------------------------------------------------------------------
// tb_program_selector
// Self-checking bench: a cycle-level behavioural model of the selector (sample
// history windows for debouncing, modular arithmetic for the wraps) is compared
// with the DUT every cycle, plus literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_program_selector;

    localparam int DB   = 4;
    localparam int HLEN = DB + 2;

    logic clk;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic btn_block;
    logic btn_load;

    int checks;
    int errors;

    program_selector_if sel_if ();

    program_selector #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_block(btn_block),
        .btn_load (btn_load),
        .bus      (sel_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int               bank_size [3] = '{10, 10, 5};
    logic [HLEN-1:0]  m_hist [4];   // bit i = raw value sampled i edges ago
    logic [3:0]       m_level;
    logic [3:0]       m_press;      // press pulses visible during the current cycle
    logic [3:0]       m_pick;
    logic [1:0]       m_block;
    logic             m_req;
    logic             m_valid = 1'b0;

    // Model update on every active edge
    always @(posedge clk) begin : model
        logic [3:0] raw;
        logic [3:0] new_press;
        logic [3:0] lvl;
        logic [HLEN-1:0] h;
        logic       all_diff;
        int         p;
        int         b;
        int         sz;
        logic       rq;
        raw = {btn_load, btn_block, btn_down, btn_up};
        if (rst) begin
            for (int k = 0; k < 4; k++) m_hist[k] <= '0;
            m_level <= 4'd0;
            m_press <= 4'd0;
            m_pick  <= 4'd0;
            m_block <= 2'd0;
            m_req   <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            p  = int'(m_pick);
            b  = int'(m_block);
            rq = m_req;
            if (rq) begin
                if (sel_if.load_ack) rq = 1'b0;
            end else if (m_press[3]) begin
                rq = 1'b1;
            end else if (m_press[2]) begin
                b = (b + 1) % 3;
                p = 0;
            end else if (m_press[0] != m_press[1]) begin
                sz = bank_size[b];
                if (m_press[0]) p = (p + 1) % sz;
                else            p = (p + sz - 1) % sz;
            end
            lvl = m_level;
            new_press = 4'd0;
            for (int k = 0; k < 4; k++) begin
                h = {m_hist[k][HLEN-2:0], raw[k]};
                all_diff = 1'b1;
                for (int i = 2; i <= DB + 1; i++) begin
                    if (h[i] == lvl[k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    lvl[k] = ~lvl[k];
                    new_press[k] = lvl[k];
                end
                m_hist[k] <= h;
            end
            m_level <= lvl;
            m_press <= new_press;
            m_pick  <= 4'(p);
            m_block <= 2'(b);
            m_req   <= rq;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic compare_model();
        if (m_valid) begin
            checks++;
            if (sel_if.pick !== m_pick || sel_if.block !== m_block || sel_if.load_req !== m_req) begin
                errors++;
                $display("FAIL model t=%0t got pick=%0d block=%0d load_req=%0b expected pick=%0d block=%0d load_req=%0b",
                         $time, sel_if.pick, sel_if.block, sel_if.load_req, m_pick, m_block, m_req);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_model();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_block = m[2];
        btn_load  = m[3];
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        set_btns(m);
        cyc(hold);
        set_btns(4'd0);
        cyc(8);
    endtask

    task automatic ack_pulse();
        sel_if.load_ack = 1'b1;
        cyc(1);
        sel_if.load_ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        set_btns(4'd0);
        sel_if.load_ack = 1'b0;
        checks = 0;
        errors = 0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("reset_pick", int'(sel_if.pick), 0);
        chk("reset_block", int'(sel_if.block), 0);
        chk("reset_req", int'(sel_if.load_req), 0);

        // Up stepping through bank 0 with wrap
        for (int i = 0; i < 9; i++) press(4'b0001, 6);
        chk("up_to_9", int'(sel_if.pick), 9);
        press(4'b0001, 6);
        chk("up_wrap_0", int'(sel_if.pick), 0);
        press(4'b0001, 6);
        chk("up_after_wrap", int'(sel_if.pick), 1);
        chk("up_block0", int'(sel_if.block), 0);

        // Down wrap in bank 2
        press(4'b0100, 6);
        press(4'b0100, 6);
        chk("block2", int'(sel_if.block), 2);
        chk("block2_pick0", int'(sel_if.pick), 0);
        press(4'b0010, 6);
        chk("down_wrap_b2", int'(sel_if.pick), 4);
        press(4'b0001, 6);
        chk("up_wrap_b2", int'(sel_if.pick), 0);

        // Bounce rejection then held press: one increment 7 cycles after the final rise
        for (int i = 0; i < 5; i++) begin
            set_btns(4'b0001);
            cyc(2);
            set_btns(4'b0000);
            cyc(2);
        end
        set_btns(4'b0001);
        cyc(6);
        chk("bounce_before", int'(sel_if.pick), 0);
        cyc(1);
        chk("bounce_at_7", int'(sel_if.pick), 1);
        cyc(20);
        chk("held_no_repeat", int'(sel_if.pick), 1);
        set_btns(4'b0000);
        cyc(8);

        // Load handshake with bank 1 pick 3
        press(4'b0100, 6);
        press(4'b0100, 6);
        for (int i = 0; i < 3; i++) press(4'b0001, 6);
        press(4'b1000, 6);
        chk("load_req_hi", int'(sel_if.load_req), 1);
        chk("load_pick", int'(sel_if.pick), 3);
        chk("load_block", int'(sel_if.block), 1);
        press(4'b0001, 6);
        press(4'b0100, 6);
        chk("pend_pick_frozen", int'(sel_if.pick), 3);
        chk("pend_block_frozen", int'(sel_if.block), 1);
        chk("pend_req_held", int'(sel_if.load_req), 1);
        ack_pulse();
        chk("ack_drops_req", int'(sel_if.load_req), 0);
        ack_pulse();
        chk("idle_ignores_ack", int'(sel_if.load_req), 0);
        chk("idle_ack_pick", int'(sel_if.pick), 3);

        // Simultaneous events
        press(4'b0011, 6);
        chk("updown_cancel", int'(sel_if.pick), 3);
        press(4'b0001, 6);
        press(4'b0001, 6);
        chk("pick5", int'(sel_if.pick), 5);
        press(4'b0101, 6);
        chk("blk_up_block", int'(sel_if.block), 2);
        chk("blk_up_pick", int'(sel_if.pick), 0);
        press(4'b1001, 6);
        chk("load_up_req", int'(sel_if.load_req), 1);
        chk("load_up_pick", int'(sel_if.pick), 0);
        ack_pulse();
        cyc(2);

        // Reset during a pending load
        press(4'b0001, 6);
        press(4'b1000, 6);
        chk("pend_before_rst", int'(sel_if.load_req), 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_req", int'(sel_if.load_req), 0);
        chk("rst_pick", int'(sel_if.pick), 0);
        chk("rst_block", int'(sel_if.block), 0);
        ack_pulse();
        cyc(2);
        chk("post_rst_ack_ignored", int'(sel_if.load_req), 0);

        // Randomized phase, checked every cycle against the model
        for (int i = 0; i < 600; i++) begin
            set_btns(4'($urandom_range(0, 15)));
            sel_if.load_ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 149) == 0);
            cyc($urandom_range(1, 7));
        end
        rst = 1'b0;
        sel_if.load_ack = 1'b0;
        set_btns(4'd0);
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
